flash_rd_ctrl: RTL and testbench

FLASH_RD_CTRL -- requirements
Module: flash_rd_ctrl

---
 rtl/flash_rd_ctrl.sv | 158 +++++++++++++++
 tb/tb_flash_rd_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_rd_ctrl.sv
// flash_rd_ctrl: single-lane SPI (mode 0) read controller for a serial flash.
// Each accepted request issues a READ (0x03) command with a 24-bit address and
// then clocks in one 32-bit word, packed little-endian by byte.
//
// Ports:
//   pll_clk        sole clock, rising edge
//   reset          synchronous, active-high
//   rd_valid       read request from core
//   rd_addr[23:0]  flash byte address, captured on accept
//   rd_ready       high only while idle
//   rd_done        one-cycle pulse, rd_rdata valid
//   rd_rdata[31:0] read word, held until the next rd_done
//   flash_csb, flash_clk           chip select (active-low) and serial clock
//   flash_io0_do / flash_io0_oeb   MOSI drive and its active-low enable
//   flash_io1_do / flash_io1_oeb   tied off, IO1 is MISO input only
//   flash_io1_di                   MISO from pad
//   flash_io2_*, flash_io3_*       WP# / HOLD# held inactive (driven high)
//   dbg_state[1:0]                 current FSM state for observation
//
// Handshake: a request is accepted on a rising edge where rd_valid && rd_ready;
// rd_addr is sampled on that edge only. rd_valid while rd_ready is low is
// ignored and leaves no trace.
module flash_rd_ctrl #(
   parameter int CLK_DIV = 1
) (
   input  logic        pll_clk,
   input  logic        reset,
   input  logic        rd_valid,
   input  logic [23:0] rd_addr,
   output logic        rd_ready,
   output logic        rd_done,
   output logic [31:0] rd_rdata,
   output logic        flash_csb,
   output logic        flash_clk,
   output logic        flash_io0_do,
   output logic        flash_io0_oeb,
   output logic        flash_io1_do,
   output logic        flash_io1_oeb,
   input  logic        flash_io1_di,
   output logic        flash_io2_do,
   output logic        flash_io2_oeb,
   output logic        flash_io3_do,
   output logic        flash_io3_oeb,
   output logic [1:0]  dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DESEL = 2'd2
   } state_t;

   localparam logic [3:0] PH_LAST = 4'(CLK_DIV - 1);

   state_t      state_q, state_d;
   logic [5:0]  slot_q, slot_d;     // bit slot 0..63
   logic [3:0]  phase_q, phase_d;   // cycle within half-period 0..CLK_DIV-1
   logic        hi_q, hi_d;         // 0: low half of slot, 1: high half
   logic [31:0] sr_q, sr_d;         // outgoing command+address, MSB first
   logic [31:0] rx_q, rx_d;         // incoming bits, first bit ends up in [31]
   logic [31:0] rdata_q, rdata_d;
   logic        done_q, done_d;
   logic        slot_end;

   // Last cycle of a slot's high half; also reused to time the deselect gap.
   assign slot_end = hi_q && (phase_q == PH_LAST);

   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      phase_d = phase_q;
      hi_d    = hi_q;
      sr_d    = sr_q;
      rx_d    = rx_q;
      rdata_d = rdata_q;
      done_d  = 1'b0;

      if (state_q != ST_IDLE) begin
         if (phase_q == PH_LAST) begin
            phase_d = 4'd0;
            hi_d    = ~hi_q;
         end else begin
            phase_d = phase_q + 4'd1;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (rd_valid) begin
               state_d = ST_SHIFT;
               sr_d    = {8'h03, rd_addr};
               slot_d  = 6'd0;
               phase_d = 4'd0;
               hi_d    = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (slot_end) begin
               // Slots 32..63 are input slots; sample as flash_clk falls.
               if (slot_q[5]) rx_d = {rx_q[30:0], flash_io1_di};
               if (slot_q == 6'd63) begin
                  state_d = ST_DESEL;
                  done_d  = 1'b1;
                  // First received byte sits in rx_d[31:24]; it becomes the low byte.
                  rdata_d = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
               end else begin
                  slot_d = slot_q + 6'd1;
                  sr_d   = {sr_q[30:0], 1'b0};
               end
            end
         end
         ST_DESEL: begin
            // Two half-periods (2*CLK_DIV cycles) of deselect before idle.
            if (slot_end) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge pll_clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         slot_q  <= 6'd0;
         phase_q <= 4'd0;
         hi_q    <= 1'b0;
         sr_q    <= 32'd0;
         rx_q    <= 32'd0;
         rdata_q <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         phase_q <= phase_d;
         hi_q    <= hi_d;
         sr_q    <= sr_d;
         rx_q    <= rx_d;
         rdata_q <= rdata_d;
         done_q  <= done_d;
      end
   end

   assign rd_ready      = (state_q == ST_IDLE);
   assign rd_done       = done_q;
   assign rd_rdata      = rdata_q;
   assign flash_csb     = (state_q != ST_SHIFT);
   assign flash_clk     = (state_q == ST_SHIFT) && hi_q;
   assign flash_io0_oeb = (state_q != ST_SHIFT);
   // sr_q only advances at slot boundaries, so MOSI changes at the start of a low half.
   assign flash_io0_do  = (state_q == ST_SHIFT) && !slot_q[5] && sr_q[31];
   assign flash_io1_do  = 1'b0;
   assign flash_io1_oeb = 1'b1;
   assign flash_io2_do  = 1'b1;
   assign flash_io2_oeb = 1'b0;
   assign flash_io3_do  = 1'b1;
   assign flash_io3_oeb = 1'b0;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// Bench for flash_rd_ctrl: two instances (CLK_DIV=1 and CLK_DIV=3), each with
// a behavioural SPI mode-0 flash that records MOSI and returns a byte stream.
module tb_flash_rd_ctrl;

   // ---------------- clock / reset ----------------
   logic pll_clk = 1'b0;
   always #5 pll_clk = ~pll_clk;

   int cyc = 0;
   always @(posedge pll_clk) cyc <= cyc + 1;

   logic        reset    [2];
   logic        rd_valid [2];
   logic [23:0] rd_addr  [2];
   logic        rd_ready [2];
   logic        rd_done  [2];
   logic [31:0] rd_rdata [2];
   logic        flash_csb [2];
   logic        flash_clk [2];
   logic        io0_do  [2];
   logic        io0_oeb [2];
   logic [1:0]  dbg_state [2];
   logic [31:0] stream   [2];   // bytes in flash send order, first byte in [31:24]

   logic [31:0] mosi_cap_w [2];
   int          done_cnt_w [2];
   int          tie_bad_w  [2];
   int          do_bad_w   [2];

   logic [31:0] exp_q[$];
   logic [31:0] exp_mosi_q[$];
   int n_cmp = 0;
   int n_err = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic io1_do, io1_oeb, io2_do, io2_oeb, io3_do, io3_oeb;
      logic di = 1'b0;
      int cnt = 0;
      logic [31:0] mosi_cap = '0;
      int done_cnt = 0;
      int tie_bad = 0;
      int do_bad = 0;

      flash_rd_ctrl #(.CLK_DIV(g == 0 ? 1 : 3)) u_dut (
         .pll_clk      (pll_clk),
         .reset        (reset[g]),
         .rd_valid     (rd_valid[g]),
         .rd_addr      (rd_addr[g]),
         .rd_ready     (rd_ready[g]),
         .rd_done      (rd_done[g]),
         .rd_rdata     (rd_rdata[g]),
         .flash_csb    (flash_csb[g]),
         .flash_clk    (flash_clk[g]),
         .flash_io0_do (io0_do[g]),
         .flash_io0_oeb(io0_oeb[g]),
         .flash_io1_do (io1_do),
         .flash_io1_oeb(io1_oeb),
         .flash_io1_di (di),
         .flash_io2_do (io2_do),
         .flash_io2_oeb(io2_oeb),
         .flash_io3_do (io3_do),
         .flash_io3_oeb(io3_oeb),
         .dbg_state    (dbg_state[g])
      );

      // Flash model: bit count restarts on CS# fall, MOSI captured on SCK rise,
      // MISO bit for the next input slot driven on SCK fall.
      always @(negedge flash_csb[g]) cnt <= 0;
      always @(posedge flash_clk[g]) begin
         if (cnt < 32) mosi_cap <= {mosi_cap[30:0], io0_do[g]};
         if (cnt < 64) cnt <= cnt + 1;
      end
      always @(negedge flash_clk[g]) begin
         if (cnt >= 32 && cnt <= 63) di <= stream[g][5'(63 - cnt)];
      end

      always @(posedge pll_clk) if (rd_done[g] === 1'b1) done_cnt <= done_cnt + 1;
      always @(negedge pll_clk) begin
         if (io1_do !== 1'b0 || io1_oeb !== 1'b1 || io2_do !== 1'b1 || io2_oeb !== 1'b0 ||
             io3_do !== 1'b1 || io3_oeb !== 1'b0)
            tie_bad <= tie_bad + 1;
         if (flash_csb[g] === 1'b0 && (cnt > 32 || (cnt == 32 && flash_clk[g] === 1'b0)) &&
             io0_do[g] !== 1'b0)
            do_bad <= do_bad + 1;
      end

      assign mosi_cap_w[g] = mosi_cap;
      assign done_cnt_w[g] = done_cnt;
      assign tie_bad_w[g]  = tie_bad;
      assign do_bad_w[g]   = do_bad;
   end

   function automatic int div_of(input int idx);
      return (idx == 0) ? 1 : 3;
   endfunction

   function automatic logic [31:0] pop_data();
      if (exp_q.size() == 0) return 'x;
      return exp_q.pop_front();
   endfunction

   function automatic logic [31:0] pop_mosi();
      if (exp_mosi_q.size() == 0) return 'x;
      return exp_mosi_q.pop_front();
   endfunction

   // ---------------- driver tasks (called at a negedge) ----------------
   // exp_word is the word the core should see; the flash sends its low byte first.
   task automatic drive_accept(input int idx, input logic [23:0] addr, input logic [31:0] exp_word,
                               input bit hold, output int acc_cyc, output bit ok);
      ok = 1'b0;
      acc_cyc = -1;
      rd_addr[idx]  = addr;
      stream[idx]   = {exp_word[7:0], exp_word[15:8], exp_word[23:16], exp_word[31:24]};
      rd_valid[idx] = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         if (rd_ready[idx] === 1'b1) begin
            acc_cyc = cyc;
            ok = 1'b1;
            break;
         end
         @(negedge pll_clk);
      end
      exp_q.push_back(exp_word);
      exp_mosi_q.push_back({8'h03, addr});
      @(negedge pll_clk);
      if (!hold) rd_valid[idx] = 1'b0;
   endtask

   task automatic wait_done(input int idx, input int budget, output int dn, output bit ok);
      ok = 1'b0;
      dn = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge pll_clk);
         if (rd_done[idx] === 1'b1) begin
            dn = cyc;
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         reset[k] = 1'b1;
         rd_valid[k] = 1'b0;
         rd_addr[k] = 24'd0;
         stream[k] = 32'd0;
      end
      repeat (3) @(negedge pll_clk);
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if (rd_ready[k] !== 1'b1) begin n_err++; $display("FAIL reset_ready[%0d]: got %b want 1", k, rd_ready[k]); end
         n_cmp++; if (flash_csb[k] !== 1'b1) begin n_err++; $display("FAIL reset_csb[%0d]: got %b want 1", k, flash_csb[k]); end
         n_cmp++; if (flash_clk[k] !== 1'b0) begin n_err++; $display("FAIL reset_clk[%0d]: got %b want 0", k, flash_clk[k]); end
         n_cmp++; if (io0_do[k] !== 1'b0) begin n_err++; $display("FAIL reset_do[%0d]: got %b want 0", k, io0_do[k]); end
         n_cmp++; if (io0_oeb[k] !== 1'b1) begin n_err++; $display("FAIL reset_oeb[%0d]: got %b want 1", k, io0_oeb[k]); end
         n_cmp++; if (rd_done[k] !== 1'b0) begin n_err++; $display("FAIL reset_done[%0d]: got %b want 0", k, rd_done[k]); end
         n_cmp++; if (rd_rdata[k] !== 32'd0) begin n_err++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rd_rdata[k]); end
      end
      for (int k = 0; k < 2; k++) reset[k] = 1'b0;
      @(negedge pll_clk);
   endtask

   task automatic test_read_div1();
      int acc, dn;
      bit ok;
      logic [31:0] ed, em;
      drive_accept(0, 24'h123456, 32'hDEADBEEF, 1'b0, acc, ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL div1_accept: got %b want 1", ok); end
      n_cmp++; if (flash_csb[0] !== 1'b0) begin n_err++; $display("FAIL div1_csb_low: got %b want 0", flash_csb[0]); end
      n_cmp++; if (io0_oeb[0] !== 1'b0) begin n_err++; $display("FAIL div1_oeb_low: got %b want 0", io0_oeb[0]); end
      wait_done(0, 300, dn, ok);
      ed = pop_data();
      em = pop_mosi();
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL div1_done_timeout: got %b want 1", ok); end
      n_cmp++; if (dn - acc !== 129) begin n_err++; $display("FAIL div1_latency: got %0d want 129", dn - acc); end
      n_cmp++; if (rd_rdata[0] !== ed) begin n_err++; $display("FAIL div1_rdata: got %h want %h", rd_rdata[0], ed); end
      n_cmp++; if (mosi_cap_w[0] !== em) begin n_err++; $display("FAIL div1_mosi: got %h want %h", mosi_cap_w[0], em); end
      n_cmp++; if (flash_csb[0] !== 1'b1) begin n_err++; $display("FAIL div1_desel_csb: got %b want 1", flash_csb[0]); end
      n_cmp++; if (flash_clk[0] !== 1'b0) begin n_err++; $display("FAIL div1_desel_clk: got %b want 0", flash_clk[0]); end
      n_cmp++; if (io0_oeb[0] !== 1'b1) begin n_err++; $display("FAIL div1_desel_oeb: got %b want 1", io0_oeb[0]); end
      @(negedge pll_clk);
      n_cmp++; if (rd_done[0] !== 1'b0) begin n_err++; $display("FAIL div1_done_pulse: got %b want 0", rd_done[0]); end
      repeat (4) @(negedge pll_clk);
   endtask

   task automatic test_read_div3();
      int acc, dn, r1, r2, f1;
      bit ok;
      logic prev;
      logic [31:0] ed, em;
      drive_accept(1, 24'h123456, 32'hDEADBEEF, 1'b0, acc, ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL div3_accept: got %b want 1", ok); end
      r1 = -1; r2 = -1; f1 = -1; dn = -1;
      prev = flash_clk[1];
      for (int i = 0; i < 500; i++) begin
         @(negedge pll_clk);
         if (flash_clk[1] === 1'b1 && prev === 1'b0) begin
            if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
         end
         if (flash_clk[1] === 1'b0 && prev === 1'b1 && f1 < 0) f1 = cyc;
         prev = flash_clk[1];
         if (rd_done[1] === 1'b1) begin dn = cyc; break; end
      end
      ed = pop_data();
      em = pop_mosi();
      n_cmp++; if (r2 - r1 !== 6) begin n_err++; $display("FAIL div3_sck_period: got %0d want 6", r2 - r1); end
      n_cmp++; if (f1 - r1 !== 3) begin n_err++; $display("FAIL div3_sck_high: got %0d want 3", f1 - r1); end
      n_cmp++; if (dn - acc !== 385) begin n_err++; $display("FAIL div3_latency: got %0d want 385", dn - acc); end
      n_cmp++; if (rd_rdata[1] !== ed) begin n_err++; $display("FAIL div3_rdata: got %h want %h", rd_rdata[1], ed); end
      n_cmp++; if (mosi_cap_w[1] !== em) begin n_err++; $display("FAIL div3_mosi: got %h want %h", mosi_cap_w[1], em); end
      repeat (8) @(negedge pll_clk);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 2; k++) begin
         int acc, dn, acc2, dn2, csb_hi, c;
         bit ok;
         logic [23:0] a2;
         logic [31:0] d2, ed, em;
         c = div_of(k);
         drive_accept(k, 24'($urandom_range(0, 24'hFFFFFF)), $urandom, 1'b1, acc, ok);
         wait_done(k, 128 * c + 20, dn, ok);
         ed = pop_data();
         em = pop_mosi();
         n_cmp++; if (rd_rdata[k] !== ed) begin n_err++; $display("FAIL b2b_rdata1[%0d]: got %h want %h", k, rd_rdata[k], ed); end
         n_cmp++; if (mosi_cap_w[k] !== em) begin n_err++; $display("FAIL b2b_mosi1[%0d]: got %h want %h", k, mosi_cap_w[k], em); end
         a2 = 24'($urandom_range(0, 24'hFFFFFF));
         d2 = $urandom;
         rd_addr[k] = a2;
         stream[k] = {d2[7:0], d2[15:8], d2[23:16], d2[31:24]};
         exp_q.push_back(d2);
         exp_mosi_q.push_back({8'h03, a2});
         csb_hi = 0;
         acc2 = -1;
         for (int i = 0; i < 4 * c + 10; i++) begin
            if (flash_csb[k] === 1'b1) csb_hi++;
            if (rd_ready[k] === 1'b1) begin acc2 = cyc; break; end
            @(negedge pll_clk);
         end
         @(negedge pll_clk);
         rd_valid[k] = 1'b0;
         n_cmp++; if (acc2 - dn !== 2 * c) begin n_err++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", k, acc2 - dn, 2 * c); end
         n_cmp++; if (csb_hi < 2 * c + 1) begin n_err++; $display("FAIL b2b_csb_high[%0d]: got %0d want >= %0d", k, csb_hi, 2 * c + 1); end
         wait_done(k, 128 * c + 20, dn2, ok);
         ed = pop_data();
         em = pop_mosi();
         n_cmp++; if (dn2 - acc2 !== 128 * c + 1) begin n_err++; $display("FAIL b2b_latency2[%0d]: got %0d want %0d", k, dn2 - acc2, 128 * c + 1); end
         n_cmp++; if (rd_rdata[k] !== ed) begin n_err++; $display("FAIL b2b_rdata2[%0d]: got %h want %h", k, rd_rdata[k], ed); end
         n_cmp++; if (mosi_cap_w[k] !== em) begin n_err++; $display("FAIL b2b_mosi2[%0d]: got %h want %h", k, mosi_cap_w[k], em); end
         repeat (8) @(negedge pll_clk);
      end
   endtask

   task automatic test_reset_mid();
      int acc, dn, base;
      bit ok;
      logic [31:0] ed, em;
      drive_accept(0, 24'hA5C3E1, 32'h0BADF00D, 1'b0, acc, ok);
      // Slot 40 starts 1 + 2*40 cycles after the accept cycle.
      while (cyc < acc + 81) @(negedge pll_clk);
      reset[0] = 1'b1;
      @(negedge pll_clk);
      n_cmp++; if (flash_csb[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_csb: got %b want 1", flash_csb[0]); end
      n_cmp++; if (flash_clk[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_clk: got %b want 0", flash_clk[0]); end
      n_cmp++; if (rd_ready[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", rd_ready[0]); end
      n_cmp++; if (io0_do[0] !== 1'b0) begin n_err++; $display("FAIL rstmid_do: got %b want 0", io0_do[0]); end
      n_cmp++; if (io0_oeb[0] !== 1'b1) begin n_err++; $display("FAIL rstmid_oeb: got %b want 1", io0_oeb[0]); end
      n_cmp++; if (rd_rdata[0] !== 32'd0) begin n_err++; $display("FAIL rstmid_rdata: got %h want 0", rd_rdata[0]); end
      reset[0] = 1'b0;
      void'(pop_data());
      void'(pop_mosi());
      base = done_cnt_w[0];
      repeat (200) @(negedge pll_clk);
      n_cmp++; if (done_cnt_w[0] !== base) begin n_err++; $display("FAIL rstmid_no_done: got %0d want %0d", done_cnt_w[0], base); end
      drive_accept(0, 24'h00FF10, 32'h13579BDF, 1'b0, acc, ok);
      wait_done(0, 300, dn, ok);
      ed = pop_data();
      em = pop_mosi();
      n_cmp++; if (dn - acc !== 129) begin n_err++; $display("FAIL rstmid_latency: got %0d want 129", dn - acc); end
      n_cmp++; if (rd_rdata[0] !== ed) begin n_err++; $display("FAIL rstmid_rdata2: got %h want %h", rd_rdata[0], ed); end
      n_cmp++; if (mosi_cap_w[0] !== em) begin n_err++; $display("FAIL rstmid_mosi2: got %h want %h", mosi_cap_w[0], em); end
      repeat (4) @(negedge pll_clk);
   endtask

   task automatic test_ignore_midshift();
      int acc, dn, base, low_cnt;
      bit ok;
      logic [31:0] ed, em;
      base = done_cnt_w[0];
      drive_accept(0, 24'h2468AC, 32'hCAFEF00D, 1'b0, acc, ok);
      while (cyc < acc + 5) @(negedge pll_clk);
      rd_addr[0] = 24'h999999;
      rd_valid[0] = 1'b1;
      n_cmp++; if (rd_ready[0] !== 1'b0) begin n_err++; $display("FAIL ign_ready: got %b want 0", rd_ready[0]); end
      @(negedge pll_clk);
      rd_valid[0] = 1'b0;
      wait_done(0, 300, dn, ok);
      ed = pop_data();
      em = pop_mosi();
      n_cmp++; if (rd_rdata[0] !== ed) begin n_err++; $display("FAIL ign_rdata: got %h want %h", rd_rdata[0], ed); end
      n_cmp++; if (mosi_cap_w[0] !== em) begin n_err++; $display("FAIL ign_mosi: got %h want %h", mosi_cap_w[0], em); end
      low_cnt = 0;
      repeat (20) begin
         @(negedge pll_clk);
         if (flash_csb[0] !== 1'b1) low_cnt++;
      end
      n_cmp++; if (low_cnt !== 0) begin n_err++; $display("FAIL ign_no_second: got %0d csb-low cycles want 0", low_cnt); end
      n_cmp++; if (done_cnt_w[0] - base !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", done_cnt_w[0] - base); end
   endtask

   task automatic test_ties();
      for (int k = 0; k < 2; k++) begin
         n_cmp++; if (tie_bad_w[k] !== 0) begin n_err++; $display("FAIL ties[%0d]: got %0d bad cycles want 0", k, tie_bad_w[k]); end
         n_cmp++; if (do_bad_w[k] !== 0) begin n_err++; $display("FAIL mosi_input_slots[%0d]: got %0d bad cycles want 0", k, do_bad_w[k]); end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_read_div1();
      test_read_div3();
      test_back_to_back();
      test_reset_mid();
      test_ignore_midshift();
      test_ties();
      n_cmp++; if (exp_q.size() !== 0) begin n_err++; $display("FAIL scoreboard_left: got %0d entries want 0", exp_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
